// File: rtl/mat_pkg.sv
// Shared constants and types for the matrix-multiply sequencing controller.
package mat_pkg;

  localparam int unsigned N     = 3;
  localparam int unsigned W     = 8;
  localparam int unsigned AW    = $clog2(N * N);
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned BEATS = N * N * N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Which operand index a sequencer emits: A[i][k] or B[k][j].
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } seq_sel_t;

endpackage

// File: rtl/mat_operand_seq.sv
// Nested i/j/k loop counter producing the row-major element index of one
// operand stream. o_term rises once all N^3 beats have been issued and stays
// high until the next clear.
module mat_operand_seq
  import mat_pkg::*;
#(
  parameter int unsigned N   = mat_pkg::N,
  parameter seq_sel_t    SEL = SEL_A,
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned AW = $clog2(N * N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_idx,
  output logic          o_term
);

  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;
  logic          r_term;
  logic          w_i_wrap;
  logic          w_j_wrap;
  logic          w_k_wrap;

  assign w_i_wrap = (r_i == IW'(N - 1));
  assign w_j_wrap = (r_j == IW'(N - 1));
  assign w_k_wrap = (r_k == IW'(N - 1));

  // Loop nest advance: k innermost, then j, then i; the last beat sets term.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_term <= 1'b0;
    end else if (i_clr) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_term <= 1'b0;
    end else if (i_en && !r_term) begin
      if (w_k_wrap) begin
        r_k <= '0;
        if (w_j_wrap) begin
          r_j <= '0;
          if (w_i_wrap) begin
            r_i    <= '0;
            r_term <= 1'b1;
          end else begin
            r_i <= r_i + IW'(1);
          end
        end else begin
          r_j <= r_j + IW'(1);
        end
      end else begin
        r_k <= r_k + IW'(1);
      end
    end
  end

  // Element index: A walks row i across k, B walks column j down k.
  always_comb begin
    if (SEL == SEL_A) begin
      o_idx = AW'(r_i) * AW'(N) + AW'(r_k);
    end else begin
      o_idx = AW'(r_k) * AW'(N) + AW'(r_j);
    end
  end

  assign o_term = r_term;

endmodule

// File: rtl/mat_mult_ctrl.sv
// Sequencing controller for the partial-product multiplier: holds the A and B
// operand matrices, streams dot-product operand pairs, and tags returned
// results with their (row, col) position in row-major order.
module mat_mult_ctrl
  import mat_pkg::*;
#(
  parameter int unsigned N   = mat_pkg::N,
  parameter int unsigned W   = mat_pkg::W,
  localparam int unsigned AW = $clog2(N * N),
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned NN = N * N
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  // operand load port
  input  logic          i_ld_we,
  input  logic          i_ld_sel,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [W-1:0]  i_ld_data,
  // control
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  // operand streams to the multiplier
  output logic [W-1:0]  o_a_num,
  output logic          o_a_num_valid,
  input  logic          i_a_read,
  output logic [W-1:0]  o_b_num,
  output logic          o_b_num_valid,
  input  logic          i_b_read,
  // results from the multiplier
  input  logic [W-1:0]  i_res_data,
  input  logic          i_res_valid,
  input  logic          i_res_last,
  output logic          o_res_ready,
  // tagged results downstream
  output logic [W-1:0]  o_c_data,
  output logic [IW-1:0] o_c_row,
  output logic [IW-1:0] o_c_col,
  output logic          o_c_valid,
  input  logic          i_c_ready,
  output logic          o_c_last
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_a_mem [NN];
  logic [W-1:0]  r_b_mem [NN];
  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;

  logic          w_start;
  logic          w_run;
  logic          w_busy;
  logic          w_ld_ok;
  logic [AW-1:0] w_a_idx;
  logic [AW-1:0] w_b_idx;
  logic          w_a_term;
  logic          w_b_term;
  logic          w_a_en;
  logic          w_b_en;
  logic          w_c_acc;
  logic          w_c_last;
  logic          w_row_wrap;
  logic          w_col_wrap;
  logic          w_unused;

  // The multiplier's last flag is redundant with the local row/col count.
  assign w_unused = i_res_last;

  assign w_start = (r_state == ST_IDLE) && i_start;
  assign w_run   = (r_state == ST_RUN);
  assign w_busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_ld_ok = (r_state == ST_IDLE) && i_ld_we && (i_ld_addr < AW'(NN));

  // Operand register files; writes only land while idle and in range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned e = 0; e < NN; e++) begin
        r_a_mem[AW'(e)] <= '0;
        r_b_mem[AW'(e)] <= '0;
      end
    end else if (w_ld_ok) begin
      if (i_ld_sel) begin
        r_b_mem[i_ld_addr] <= i_ld_data;
      end else begin
        r_a_mem[i_ld_addr] <= i_ld_data;
      end
    end
  end

  assign o_a_num_valid = w_run && !w_a_term;
  assign o_b_num_valid = w_run && !w_b_term;
  assign w_a_en        = o_a_num_valid && i_a_read;
  assign w_b_en        = o_b_num_valid && i_b_read;

  mat_operand_seq #(
    .N   (N),
    .SEL (SEL_A)
  ) u_a_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_en    (w_a_en),
    .o_idx   (w_a_idx),
    .o_term  (w_a_term)
  );

  mat_operand_seq #(
    .N   (N),
    .SEL (SEL_B)
  ) u_b_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_en    (w_b_en),
    .o_idx   (w_b_idx),
    .o_term  (w_b_term)
  );

  assign o_a_num = r_a_mem[w_a_idx];
  assign o_b_num = r_b_mem[w_b_idx];

  // Result pass-through, gated to the active states.
  assign o_c_data    = i_res_data;
  assign o_c_valid   = i_res_valid && w_busy;
  assign o_res_ready = i_c_ready && w_busy;
  assign w_c_acc     = o_c_valid && i_c_ready;

  assign w_row_wrap = (r_row == IW'(N - 1));
  assign w_col_wrap = (r_col == IW'(N - 1));
  assign w_c_last   = w_row_wrap && w_col_wrap;

  // Output position counter, row-major, restarted by each accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_c_acc) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + IW'(1);
      end else begin
        r_col <= r_col + IW'(1);
      end
    end
  end

  assign o_c_row  = r_row;
  assign o_c_col  = r_col;
  assign o_c_last = w_c_last;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: the final accepted result wins over the drain move.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_c_acc && w_c_last) begin
          w_state_nxt = ST_DONE;
        end else if (w_a_term && w_b_term) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_c_acc && w_c_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_busy = w_busy;
  assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Bench for mat_mult_ctrl: a behavioural multiplier consumes the operand
// streams and returns dot products; results are checked against C = A x B
// computed directly from the loaded matrices.
module tb_mat_mult_ctrl;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int NN = 9;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ld_we = 1'b0;
  logic       i_ld_sel = 1'b0;
  logic [3:0] i_ld_addr = '0;
  logic [7:0] i_ld_data = '0;
  logic       i_start = 1'b0;
  logic       o_busy, o_done;
  logic [7:0] o_a_num, o_b_num;
  logic       o_a_num_valid, o_b_num_valid;
  logic       i_a_read = 1'b0;
  logic       i_b_read = 1'b0;
  logic [7:0] i_res_data = '0;
  logic       i_res_valid = 1'b0;
  logic       i_res_last = 1'b0;
  logic       o_res_ready;
  logic [7:0] o_c_data;
  logic [1:0] o_c_row, o_c_col;
  logic       o_c_valid;
  logic       i_c_ready = 1'b0;
  logic       o_c_last;

  mat_mult_ctrl #(.N(N), .W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ld_we(i_ld_we), .i_ld_sel(i_ld_sel), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_a_num(o_a_num), .o_a_num_valid(o_a_num_valid), .i_a_read(i_a_read),
    .o_b_num(o_b_num), .o_b_num_valid(o_b_num_valid), .i_b_read(i_b_read),
    .i_res_data(i_res_data), .i_res_valid(i_res_valid), .i_res_last(i_res_last),
    .o_res_ready(o_res_ready),
    .o_c_data(o_c_data), .o_c_row(o_c_row), .o_c_col(o_c_col), .o_c_valid(o_c_valid),
    .i_c_ready(i_c_ready), .o_c_last(o_c_last)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] ma [NN];
  logic [7:0] mb [NN];
  logic [7:0] aq [$];
  logic [7:0] bq [$];
  logic [7:0] resq [$];

  logic [7:0] g_data [NN];
  logic [1:0] g_row [NN];
  logic [1:0] g_col [NN];
  logic       g_last [NN];
  int         g_n, g_a_beats, g_b_beats, g_done_cyc, g_last_cyc, g_done_cnt, g_pass_err;
  logic       g_busy_after;
  logic [4:0] g_idle_out;
  logic [2:0] g_start_flags;
  logic [7:0] g_start_a, g_start_b;
  bit         g_timeout, g_aborted;

  // Reference: C[r][c] = sum_k A[r][k]*B[k][c], truncated to W bits.
  function automatic logic [7:0] ref_c(int r, int c);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(ma[r*N+k]) * int'(mb[k*N+c]);
    return 8'(s);
  endfunction

  task automatic load_all();
    for (int e = 0; e < NN; e++) begin
      for (int s = 0; s < 2; s++) begin
        @(negedge i_clk);
        i_ld_we = 1'b1; i_ld_sel = 1'(s); i_ld_addr = 4'(e);
        i_ld_data = (s == 1) ? mb[e] : ma[e];
      end
    end
    @(negedge i_clk);
    i_ld_we = 1'b0;
  endtask

  task automatic quiet_inputs();
    i_start = 0; i_ld_we = 0; i_a_read = 0; i_b_read = 0;
    i_res_valid = 0; i_res_data = 0; i_res_last = 0; i_c_ready = 0;
  endtask

  // Start one job and emulate the multiplier until done (or abort/timeout).
  task automatic run_job(input int rdy_mode, input int rd_mode, input bit poke, input int abort_at);
    int m_acc; int m_pairs; bit fin; logic [7:0] av, bv;
    m_acc = 0; m_pairs = 0; fin = 0;
    aq.delete(); bq.delete(); resq.delete();
    g_n = 0; g_a_beats = 0; g_b_beats = 0; g_done_cyc = -1; g_last_cyc = -1;
    g_done_cnt = 0; g_pass_err = 0; g_busy_after = 1'bx; g_idle_out = 'x;
    g_timeout = 0; g_aborted = 0;
    for (int e = 0; e < NN; e++) begin
      g_data[e] = 'x; g_row[e] = 'x; g_col[e] = 'x; g_last[e] = 1'bx;
    end
    i_start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge i_clk);
      i_start   = poke && (cyc == 6);
      i_ld_we   = poke && (cyc >= 6) && (cyc < 10);
      i_ld_sel  = 1'($urandom);
      i_ld_addr = 4'($urandom);
      i_ld_data = 8'($urandom);
      case (rdy_mode)
        0:       i_c_ready = 1'b1;
        1:       i_c_ready = (cyc % 2 == 0);
        default: i_c_ready = 1'($urandom);
      endcase
      i_a_read    = (rd_mode == 0) ? 1'b1 : 1'($urandom);
      i_b_read    = (rd_mode == 0) ? 1'b1 : 1'($urandom);
      i_res_valid = (resq.size() > 0);
      i_res_data  = (resq.size() > 0) ? resq[0] : 8'($urandom);
      i_res_last  = (resq.size() > 0) && (g_n == NN - 1);
      #1;
      if (cyc == 0) begin
        g_start_flags = {o_busy, o_a_num_valid, o_b_num_valid};
        g_start_a = o_a_num; g_start_b = o_b_num;
      end
      if (o_res_ready !== (i_c_ready && o_busy)) g_pass_err++;
      if (o_c_valid !== (i_res_valid && o_busy)) g_pass_err++;
      if (o_c_valid && (o_c_data !== i_res_data)) g_pass_err++;
      if (o_done === 1'b1) begin
        g_done_cnt++;
        if (g_done_cyc < 0) g_done_cyc = cyc;
      end
      if (g_done_cyc >= 0 && cyc == g_done_cyc + 1) begin
        g_busy_after = o_busy;
        g_idle_out = {o_a_num_valid, o_b_num_valid, o_c_valid, o_res_ready, o_done};
        fin = 1;
        break;
      end
      if (o_a_num_valid && i_a_read) begin aq.push_back(o_a_num); g_a_beats++; end
      if (o_b_num_valid && i_b_read) begin bq.push_back(o_b_num); g_b_beats++; end
      if (o_c_valid && i_c_ready) begin
        if (g_n < NN) begin
          g_data[g_n] = o_c_data; g_row[g_n] = o_c_row;
          g_col[g_n] = o_c_col; g_last[g_n] = o_c_last;
        end
        g_n++;
        if (g_n == NN) g_last_cyc = cyc;
        if (resq.size() > 0) void'(resq.pop_front());
      end
      while (aq.size() > 0 && bq.size() > 0) begin
        av = aq.pop_front(); bv = bq.pop_front();
        m_acc += int'(av) * int'(bv);
        m_pairs++;
        if (m_pairs == N) begin resq.push_back(8'(m_acc)); m_acc = 0; m_pairs = 0; end
      end
      if (abort_at > 0 && g_a_beats >= abort_at) begin g_aborted = 1; fin = 1; break; end
    end
    i_start = 1'b0; i_ld_we = 1'b0;
    if (!fin) g_timeout = 1;
  endtask

  task automatic test_reset();
    quiet_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if ({o_busy, o_done, o_a_num_valid, o_b_num_valid, o_c_valid, o_res_ready, o_c_last} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000", {o_busy, o_done, o_a_num_valid, o_b_num_valid, o_c_valid, o_res_ready, o_c_last});
    end
    checks++; if ({o_a_num, o_b_num} !== 16'h0) begin
      errors++; $display("FAIL reset_nums: got %h expected 0000", {o_a_num, o_b_num});
    end
    checks++; if ({o_c_row, o_c_col} !== 4'h0) begin
      errors++; $display("FAIL reset_rowcol: got %h expected 0", {o_c_row, o_c_col});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_identity();
    for (int e = 0; e < NN; e++) begin
      ma[e] = (e / N == e % N) ? 8'd1 : 8'd0;
      mb[e] = 8'(e + 1);
    end
    load_all();
    run_job(0, 0, 0, 0);
    checks++; if (g_timeout) begin errors++; $display("FAIL ident_timeout: got timeout expected done"); end
    checks++; if (g_start_flags !== 3'b111) begin errors++; $display("FAIL ident_start_flags: got %b expected 111", g_start_flags); end
    checks++; if ({g_start_a, g_start_b} !== {ma[0], mb[0]}) begin
      errors++; $display("FAIL ident_start_elem: got %h expected %h", {g_start_a, g_start_b}, {ma[0], mb[0]});
    end
    checks++; if (g_n !== NN) begin errors++; $display("FAIL ident_count: got %0d expected %0d", g_n, NN); end
    for (int e = 0; e < NN; e++) begin
      checks++; if (g_data[e] !== 8'(e + 1)) begin
        errors++; $display("FAIL ident_data[%0d]: got %h expected %h", e, g_data[e], 8'(e + 1));
      end
      checks++; if ({g_row[e], g_col[e], g_last[e]} !== {2'(e / N), 2'(e % N), (e == NN - 1)}) begin
        errors++; $display("FAIL ident_tag[%0d]: got %b expected %b", e, {g_row[e], g_col[e], g_last[e]}, {2'(e / N), 2'(e % N), (e == NN - 1)});
      end
    end
    checks++; if (g_done_cyc !== g_last_cyc + 1) begin
      errors++; $display("FAIL ident_done_time: got cycle %0d expected %0d", g_done_cyc, g_last_cyc + 1);
    end
    checks++; if (g_done_cnt !== 1) begin errors++; $display("FAIL ident_done_width: got %0d expected 1", g_done_cnt); end
    checks++; if ({g_busy_after, g_idle_out} !== 6'b0) begin
      errors++; $display("FAIL ident_idle_after: got %b expected 000000", {g_busy_after, g_idle_out});
    end
  endtask

  task automatic test_known_product();
    for (int e = 0; e < NN; e++) begin ma[e] = 8'h10; mb[e] = 8'h10; end
    load_all();
    run_job(0, 1, 0, 0);
    checks++; if (g_timeout) begin errors++; $display("FAIL known_timeout: got timeout expected done"); end
    checks++; if ({g_a_beats, g_b_beats} !== {32'd27, 32'd27}) begin
      errors++; $display("FAIL known_beats: got a=%0d b=%0d expected 27 each", g_a_beats, g_b_beats);
    end
    checks++; if (g_n !== NN) begin errors++; $display("FAIL known_count: got %0d expected %0d", g_n, NN); end
    for (int e = 0; e < NN; e++) begin
      checks++; if (g_data[e] !== 8'h00) begin
        errors++; $display("FAIL known_data[%0d]: got %h expected 00", e, g_data[e]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int e = 0; e < NN; e++) begin ma[e] = 8'($urandom); mb[e] = 8'($urandom); end
    load_all();
    run_job(1, 1, 0, 0);
    checks++; if (g_timeout) begin errors++; $display("FAIL bp_timeout: got timeout expected done"); end
    checks++; if (g_n !== NN) begin errors++; $display("FAIL bp_count: got %0d expected %0d", g_n, NN); end
    checks++; if (g_pass_err !== 0) begin errors++; $display("FAIL bp_passthrough: got %0d bad cycles expected 0", g_pass_err); end
    for (int e = 0; e < NN; e++) begin
      checks++; if (g_data[e] !== ref_c(e / N, e % N)) begin
        errors++; $display("FAIL bp_data[%0d]: got %h expected %h", e, g_data[e], ref_c(e / N, e % N));
      end
      checks++; if ({g_row[e], g_col[e]} !== {2'(e / N), 2'(e % N)}) begin
        errors++; $display("FAIL bp_pos[%0d]: got %b expected %b", e, {g_row[e], g_col[e]}, {2'(e / N), 2'(e % N)});
      end
    end
  endtask

  task automatic test_illegal();
    for (int e = 0; e < NN; e++) begin ma[e] = 8'($urandom); mb[e] = 8'($urandom); end
    load_all();
    // Out-of-range addresses while idle must not touch either matrix.
    for (int a = NN; a < 16; a++) begin
      @(negedge i_clk);
      i_ld_we = 1'b1; i_ld_sel = 1'(a); i_ld_addr = 4'(a); i_ld_data = 8'hFF;
    end
    @(negedge i_clk);
    i_ld_we = 1'b0;
    run_job(2, 1, 1, 0);
    checks++; if (g_timeout) begin errors++; $display("FAIL illegal_timeout: got timeout expected done"); end
    checks++; if ({g_a_beats, g_b_beats} !== {32'd27, 32'd27}) begin
      errors++; $display("FAIL illegal_beats: got a=%0d b=%0d expected 27 each", g_a_beats, g_b_beats);
    end
    checks++; if (g_n !== NN) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", g_n, NN); end
    for (int e = 0; e < NN; e++) begin
      checks++; if (g_data[e] !== ref_c(e / N, e % N)) begin
        errors++; $display("FAIL illegal_data[%0d]: got %h expected %h", e, g_data[e], ref_c(e / N, e % N));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < NN; e++) begin ma[e] = 8'($urandom_range(1, 255)); mb[e] = 8'($urandom_range(1, 255)); end
    load_all();
    run_job(0, 0, 0, 10);
    checks++; if (!g_aborted) begin errors++; $display("FAIL rstmid_reach: got no abort expected 10 beats"); end
    quiet_inputs();
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_busy, o_done, o_a_num_valid, o_b_num_valid, o_c_valid, o_res_ready, o_c_last} !== 7'b0) begin
      errors++; $display("FAIL rstmid_flags: got %b expected 0000000", {o_busy, o_done, o_a_num_valid, o_b_num_valid, o_c_valid, o_res_ready, o_c_last});
    end
    checks++; if ({o_a_num, o_b_num, o_c_row, o_c_col} !== 20'h0) begin
      errors++; $display("FAIL rstmid_vals: got %h expected 00000", {o_a_num, o_b_num, o_c_row, o_c_col});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int e = 0; e < NN; e++) begin ma[e] = 8'h0; mb[e] = 8'h0; end
    run_job(0, 0, 0, 0);
    checks++; if (g_n !== NN) begin errors++; $display("FAIL rstmid_zero_count: got %0d expected %0d", g_n, NN); end
    for (int e = 0; e < NN; e++) begin
      checks++; if (g_data[e] !== 8'h00) begin
        errors++; $display("FAIL rstmid_cleared[%0d]: got %h expected 00", e, g_data[e]);
      end
    end
    for (int e = 0; e < NN; e++) begin ma[e] = 8'($urandom); mb[e] = 8'($urandom); end
    load_all();
    run_job(2, 1, 0, 0);
    checks++; if (g_n !== NN) begin errors++; $display("FAIL rstmid_reload_count: got %0d expected %0d", g_n, NN); end
    for (int e = 0; e < NN; e++) begin
      checks++; if (g_data[e] !== ref_c(e / N, e % N)) begin
        errors++; $display("FAIL rstmid_reload[%0d]: got %h expected %h", e, g_data[e], ref_c(e / N, e % N));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first [NN];
    for (int e = 0; e < NN; e++) begin ma[e] = 8'($urandom); mb[e] = 8'($urandom); end
    load_all();
    run_job(0, 0, 0, 0);
    for (int e = 0; e < NN; e++) first[e] = g_data[e];
    run_job(2, 1, 0, 0);
    checks++; if (g_timeout) begin errors++; $display("FAIL b2b_timeout: got timeout expected done"); end
    checks++; if (g_start_flags !== 3'b111) begin errors++; $display("FAIL b2b_start_flags: got %b expected 111", g_start_flags); end
    checks++; if ({g_start_a, g_start_b} !== {ma[0], mb[0]}) begin
      errors++; $display("FAIL b2b_start_elem: got %h expected %h", {g_start_a, g_start_b}, {ma[0], mb[0]});
    end
    checks++; if ({g_row[0], g_col[0]} !== 4'h0) begin
      errors++; $display("FAIL b2b_first_pos: got %h expected 0", {g_row[0], g_col[0]});
    end
    for (int e = 0; e < NN; e++) begin
      checks++; if (first[e] !== ref_c(e / N, e % N) || g_data[e] !== ref_c(e / N, e % N)) begin
        errors++; $display("FAIL b2b_data[%0d]: got %h/%h expected %h", e, first[e], g_data[e], ref_c(e / N, e % N));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int e = 0; e < NN; e++) begin ma[e] = 8'($urandom); mb[e] = 8'($urandom); end
      load_all();
      run_job(2, 1, 0, 0);
      checks++; if (g_n !== NN || g_pass_err !== 0) begin
        errors++; $display("FAIL rand%0d_count: got n=%0d passerr=%0d expected n=9 passerr=0", it, g_n, g_pass_err);
      end
      for (int e = 0; e < NN; e++) begin
        checks++; if ({g_data[e], g_row[e], g_col[e], g_last[e]} !== {ref_c(e / N, e % N), 2'(e / N), 2'(e % N), (e == NN - 1)}) begin
          errors++; $display("FAIL rand%0d_elem[%0d]: got %h expected %h", it, e, {g_data[e], g_row[e], g_col[e], g_last[e]}, {ref_c(e / N, e % N), 2'(e / N), 2'(e % N), (e == NN - 1)});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_known_product();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_mult_ctrl.md
# mat_mult_ctrl

Sequencing controller for the `mat_partial_mult` datapath. It holds an N×N operand matrix A and an N×N operand matrix B in internal register files, loaded through a write port. On start it streams the operand pairs A[i][k] / B[k][j] into the multiplier, one dot product per output element, in row-major output order. It tags each returned result beat with its (row, col) position, forwards it downstream, and signals completion after N·N results.

## Interface
Parameters:
- `N`, 3: matrix dimension (N ≥ 2).
- `W`, 8: element width (operands and results).

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_ld_we`  in  1  operand write strobe; honoured only in IDLE.
- `i_ld_sel`  in  1  target matrix: 0 = A, 1 = B.
- `i_ld_addr`  in  AW = $clog2(N·N)  row-major element index (r·N + c); indices ≥ N·N are ignored.
- `i_ld_data`  in  W  element value.
- `i_start`  in  1  start pulse; honoured only in IDLE.
- `o_busy`  out  1  high in RUN and DRAIN.
- `o_done`  out  1  one-cycle pulse in the DONE state.
- `o_a_num`  out  W  to `mat_partial_mult` `i_a_num`.
- `o_a_num_valid`  out  1  to `i_a_num_valid`.
- `i_a_read`  in  1  from `o_a_read`; the A element is consumed when this is high at a clock edge.
- `o_b_num`, `o_b_num_valid`, `i_b_read`: same as the A stream, for B.
- `i_res_data`  in  W  from `o_res_data`.
- `i_res_valid`  in  1  from `o_res_valid`.
- `i_res_last`  in  1  from `o_res_last`; ignored for counting.
- `o_res_ready`  out  1  to `i_res_ready`.
- `o_c_data`  out  W  result element.
- `o_c_row`, `o_c_col`  out  $clog2(N)  position of `o_c_data`.
- `o_c_valid`  out  1  result valid.
- `i_c_ready`  in  1  downstream ready.
- `o_c_last`  out  1  high with the element at (N−1, N−1).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `i_start`.
  - RUN → DRAIN when both operand streams have issued N³ beats and result count < N·N.
  - RUN or DRAIN → DONE when the N·N-th result is accepted.
  - DONE → IDLE unconditionally after one cycle.
- Load: when `i_ld_we` is high in IDLE, the addressed element of the selected matrix is written at the clock edge. Writes in any other state are dropped. Contents persist across runs.
- A stream: beat sequence is, for i, for j, for k: A[i][k], N³ beats in total.
- B stream: same loop nest, emitting B[k][j].
- The A and B streams have independent counters and advance only on their own `*_read`; neither waits for the other.
- `o_x_num_valid` is high in RUN while that stream's count < N³. `o_x_num` is a combinational read at the current index.
- Results: a combinational pass-through.
  - `o_c_data = i_res_data`.
  - `o_c_valid = i_res_valid` AND (RUN or DRAIN).
  - `o_res_ready = i_c_ready` AND (RUN or DRAIN).
  - A beat is accepted when `o_c_valid` and `i_c_ready` are both high. The row/col counter advances (col wraps at N−1 and increments row), and `o_c_last` = (row == N−1 && col == N−1).
- `i_start` while busy: ignored, with no effect on counters.
- Arithmetic wrap or overflow is the multiplier's concern; the controller never alters data.

## Timing
- Reset values: state IDLE. All counters 0. Register files all 0. `o_busy`, `o_done`, `o_a_num_valid`, `o_b_num_valid`, `o_c_valid`, `o_res_ready`, `o_c_last` are 0. `o_a_num`, `o_b_num`, `o_c_row`, `o_c_col` are 0.
- Start latency: `i_start` sampled at edge t gives `o_busy` and both valids high from cycle t+1, with element index 0 presented.
- Operand index: advances on the edge where `*_read` is high. The new element appears in the same cycle the read-side counter updates, so there are no bubbles with continuous reads.
- Done: if the last result is accepted at edge t, `o_done` is high during cycle t+1, and the block is in IDLE with `o_busy` low at t+2.
- A result accepted in the same cycle that the final operand beat issues is counted; there is no ordering dependency.
- Reset asserted mid-run: everything, including the register files, clears immediately. Outstanding multiplier state is the multiplier's responsibility, and the bench resets both together.
- Backpressure: while `i_c_ready` is low, `o_res_ready` is low, the row/col counter holds, and the multiplier stalls naturally.

## Structure
- Shared package `mat_pkg`: `N`, `W`, `AW`, `IW = $clog2(N)`, state enum (IDLE/RUN/DRAIN/DONE), localparam `BEATS = N·N·N`.
- Sub-module `mat_operand_seq`: a nested i/j/k counter with enable, terminal flag and sync clear, instantiated once per stream. Its `sel` parameter chooses the A index (i·N+k) or the B index (k·N+j).

## Test plan
- Identity × B: load A = I, B = 1..9 row-major, start, `i_c_ready` = 1. Expect C = 1..9 with correct row/col, `o_c_last` on the 9th beat, and `o_done` exactly one cycle later.
- Known product: A = B = all 0x10. Expect every C element = 3·0x100 truncated by the multiplier, exactly 9 beats, and 27 beats accepted on each operand stream.
- Backpressure: toggle `i_c_ready` 1/0 every cycle. Expect no lost or duplicated results, `o_res_ready` to mirror `i_c_ready` during busy, and the same C values as unstalled.
- Illegal requests: pulse `i_start` and `i_ld_we` mid-RUN. Expect no restart, the matrix unchanged, and results identical to the clean run.
- Reset mid-run: deassert `i_rst_n` after 10 operand beats. Expect all outputs at reset values and A/B cleared to 0; then reload, start, and expect a correct full result.
- Back-to-back runs: start again in the cycle after `o_busy` falls. Expect the second C identical, with counters restarting at (0,0).
